// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the change controller and the coin-return block.
interface change_dispenser_if;
   logic       start;
   logic [7:0] amount;
   logic       restock;
   logic       coin_pulse;
   logic [7:0] coin_value;
   logic       busy;
   logic       done;
   logic       short;
   logic [7:0] remaining;
   logic       eject5;
   logic       eject2;
   logic       eject1;
   logic       coin_reject;
   logic [3:0] tube5;
   logic [3:0] tube2;
   logic [3:0] tube1;

   modport master (
      output start, amount, restock, coin_pulse, coin_value,
      input  busy, done, short, remaining, eject5, eject2, eject1,
             coin_reject, tube5, tube2, tube1
   );

   modport slave (
      input  start, amount, restock, coin_pulse, coin_value,
      output busy, done, short, remaining, eject5, eject2, eject1,
             coin_reject, tube5, tube2, tube1
   );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-return sequencer paying change from 5/2/1 tubes as timed eject pulses.
// Optional CHANGE_INSERT_EN: inserted coins refill the tubes or raise coin_reject.
//
// state  | meaning
// IDLE   | waiting for start; restock allowed
// SELECT | pick largest payable coin, or finish
// PULSE  | chosen ejector driven for PULSE_CYCLES
// GAP    | all ejectors low for GAP_CYCLES
// DONE   | one-cycle completion, short flag updated
module change_dispenser #(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 4,
   parameter int TUBE5_INIT   = 15,
   parameter int TUBE2_INIT   = 15,
   parameter int TUBE1_INIT   = 15
) (
   input logic                clk,
   input logic                rst,
   change_dispenser_if.slave  bus
);

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;
   typedef enum logic [1:0] {C_NONE, C_5, C_2, C_1} coin_t;

   localparam int CW = 16;
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
   localparam logic [3:0]    T5_I     = 4'(TUBE5_INIT);
   localparam logic [3:0]    T2_I     = 4'(TUBE2_INIT);
   localparam logic [3:0]    T1_I     = 4'(TUBE1_INIT);

   state_t          state, state_nxt;
   coin_t           coin, coin_nxt, pick;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [7:0]      pick_val;
   logic [7:0]      remaining;
   logic            short_q;
   logic            reject_q, reject_nxt;
   logic [3:0]      t5, t2, t1;
   logic            inc5, inc2, inc1;
   logic            dec5, dec2, dec1;
   logic            restock_now;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         coin  <= C_NONE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         coin  <= coin_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      coin_nxt  = coin;
      cnt_nxt   = cnt;
      pick      = C_NONE;
      pick_val  = 8'd0;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = S_SELECT;
         end
         S_SELECT: begin
            if (remaining >= 8'd5 && t5 != 4'd0) begin
               pick     = C_5;
               pick_val = 8'd5;
            end else if (remaining >= 8'd2 && t2 != 4'd0) begin
               pick     = C_2;
               pick_val = 8'd2;
            end else if (remaining != 8'd0 && t1 != 4'd0) begin
               pick     = C_1;
               pick_val = 8'd1;
            end
            if (pick != C_NONE) begin
               coin_nxt  = pick;
               cnt_nxt   = PULSE_LD;
               state_nxt = S_PULSE;
            end else begin
               state_nxt = S_DONE;
            end
         end
         S_PULSE: begin
            if (cnt == '0) begin
               cnt_nxt   = GAP_LD;
               state_nxt = S_GAP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt == '0) state_nxt = S_SELECT;
            else           cnt_nxt   = cnt - 1'b1;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef CHANGE_INSERT_EN
   always_comb begin
      inc5       = 1'b0;
      inc2       = 1'b0;
      inc1       = 1'b0;
      reject_nxt = 1'b0;
      if (bus.coin_pulse) begin
         case (bus.coin_value)
            8'd5: if (t5 != 4'd15) inc5 = 1'b1; else reject_nxt = 1'b1;
            8'd2: if (t2 != 4'd15) inc2 = 1'b1; else reject_nxt = 1'b1;
            8'd1: if (t1 != 4'd15) inc1 = 1'b1; else reject_nxt = 1'b1;
            default: reject_nxt = 1'b1;
         endcase
      end
   end
`else
   logic unused_insert;
   assign unused_insert = ^{bus.coin_pulse, bus.coin_value};
   assign inc5       = 1'b0;
   assign inc2       = 1'b0;
   assign inc1       = 1'b0;
   assign reject_nxt = 1'b0;
`endif

   assign dec5        = (pick == C_5);
   assign dec2        = (pick == C_2);
   assign dec1        = (pick == C_1);
   assign restock_now = (state == S_IDLE) && bus.restock;

   // Restock wins over a same-cycle inserted coin; increments are pre-checked against 15.
   always_ff @(posedge clk) begin
      if (!rst) begin
         remaining <= 8'd0;
         short_q   <= 1'b0;
         reject_q  <= 1'b0;
         t5        <= T5_I;
         t2        <= T2_I;
         t1        <= T1_I;
      end else begin
         reject_q <= reject_nxt;
         if (state == S_IDLE && bus.start) begin
            remaining <= bus.amount;
            short_q   <= 1'b0;
         end else if (state == S_SELECT) begin
            remaining <= remaining - pick_val;
         end else if (state == S_DONE) begin
            short_q <= (remaining != 8'd0);
         end
         if (restock_now) begin
            t5 <= T5_I;
            t2 <= T2_I;
            t1 <= T1_I;
         end else begin
            t5 <= t5 + {3'b000, inc5} - {3'b000, dec5};
            t2 <= t2 + {3'b000, inc2} - {3'b000, dec2};
            t1 <= t1 + {3'b000, inc1} - {3'b000, dec1};
         end
      end
   end

   assign bus.busy        = (state == S_SELECT) || (state == S_PULSE) || (state == S_GAP);
   assign bus.done        = (state == S_DONE);
   assign bus.short       = short_q;
   assign bus.remaining   = remaining;
   assign bus.eject5      = (state == S_PULSE) && (coin == C_5);
   assign bus.eject2      = (state == S_PULSE) && (coin == C_2);
   assign bus.eject1      = (state == S_PULSE) && (coin == C_1);
   assign bus.coin_reject = reject_q;
   assign bus.tube5       = t5;
   assign bus.tube2       = t2;
   assign bus.tube1       = t1;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: three tube configurations driven in lockstep,
// checked against a greedy arithmetic payout model.
module tb_change_dispenser;

   localparam int P   = 4;
   localparam int G   = 4;
   localparam int PER = 1 + P + G;
   localparam int I5 [3] = '{15, 0, 1};
   localparam int I2 [3] = '{15, 15, 1};
   localparam int I1 [3] = '{15, 15, 1};
   localparam int VAL [3] = '{5, 2, 1};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] amount = 8'd0;
   logic       restock = 1'b0;
   logic       coin_pulse = 1'b0;
   logic [7:0] coin_value = 8'd0;

   int total = 0;
   int bad   = 0;
   int mt [3][3];

   always #5 clk = ~clk;

   change_dispenser_if if_a ();
   change_dispenser_if if_b ();
   change_dispenser_if if_c ();

   assign if_a.start = start;       assign if_b.start = start;       assign if_c.start = start;
   assign if_a.amount = amount;     assign if_b.amount = amount;     assign if_c.amount = amount;
   assign if_a.restock = restock;   assign if_b.restock = restock;   assign if_c.restock = restock;
   assign if_a.coin_pulse = coin_pulse;
   assign if_b.coin_pulse = coin_pulse;
   assign if_c.coin_pulse = coin_pulse;
   assign if_a.coin_value = coin_value;
   assign if_b.coin_value = coin_value;
   assign if_c.coin_value = coin_value;

   change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G),
      .TUBE5_INIT(15), .TUBE2_INIT(15), .TUBE1_INIT(15)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G),
      .TUBE5_INIT(0), .TUBE2_INIT(15), .TUBE1_INIT(15)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
   change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G),
      .TUBE5_INIT(1), .TUBE2_INIT(1), .TUBE1_INIT(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

   logic [2:0] ej [3];
   logic       bsy [3], dn [3], sh [3], rj [3];
   logic [7:0] rem_o [3];
   logic [3:0] tu [3][3];

   assign ej[0] = {if_a.eject5, if_a.eject2, if_a.eject1};
   assign ej[1] = {if_b.eject5, if_b.eject2, if_b.eject1};
   assign ej[2] = {if_c.eject5, if_c.eject2, if_c.eject1};
   assign bsy[0] = if_a.busy;  assign bsy[1] = if_b.busy;  assign bsy[2] = if_c.busy;
   assign dn[0] = if_a.done;   assign dn[1] = if_b.done;   assign dn[2] = if_c.done;
   assign sh[0] = if_a.short;  assign sh[1] = if_b.short;  assign sh[2] = if_c.short;
   assign rj[0] = if_a.coin_reject;
   assign rj[1] = if_b.coin_reject;
   assign rj[2] = if_c.coin_reject;
   assign rem_o[0] = if_a.remaining;
   assign rem_o[1] = if_b.remaining;
   assign rem_o[2] = if_c.remaining;
   assign tu[0][0] = if_a.tube5;  assign tu[0][1] = if_a.tube2;  assign tu[0][2] = if_a.tube1;
   assign tu[1][0] = if_b.tube5;  assign tu[1][1] = if_b.tube2;  assign tu[1][2] = if_b.tube1;
   assign tu[2][0] = if_c.tube5;  assign tu[2][1] = if_c.tube2;  assign tu[2][2] = if_c.tube1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_restock();
      for (int d = 0; d < 3; d++) begin
         mt[d][0] = I5[d];
         mt[d][1] = I2[d];
         mt[d][2] = I1[d];
      end
   endtask

   task automatic check_tubes(input string tag);
      for (int d = 0; d < 3; d++)
         for (int v = 0; v < 3; v++)
            chk($sformatf("%s_d%0d_tube%0d", tag, d, VAL[v]), 32'(tu[d][v]), 32'(mt[d][v]));
   endtask

   // Greedy payout: largest coin value while it fits and the tube has stock.
   task automatic dispense(input logic [7:0] amt, input bit with_restock, input string tag);
      int clist [3][256];
      int ncoin [3];
      int exp_rem [3];
      int exp_done [3];
      int done_at [3];
      int err [3];
      int lim;
      int rem;
      if (with_restock) model_restock();
      lim = 0;
      for (int d = 0; d < 3; d++) begin
         rem = amt;
         ncoin[d] = 0;
         for (int v = 0; v < 3; v++) begin
            while (rem >= VAL[v] && mt[d][v] > 0) begin
               clist[d][ncoin[d]] = VAL[v];
               ncoin[d]++;
               rem -= VAL[v];
               mt[d][v]--;
            end
         end
         exp_rem[d]  = rem;
         exp_done[d] = 2 + ncoin[d] * PER;
         done_at[d]  = 0;
         err[d]      = 0;
         if (exp_done[d] > lim) lim = exp_done[d];
      end
      lim += 3;

      @(negedge clk);
      start = 1'b1;
      amount = amt;
      restock = with_restock;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      restock = 1'b0;
      amount = $urandom_range(0, 255);

      for (int k = 1; k <= lim; k++) begin
         if (k > 1) @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            int i, ph;
            logic [2:0] e_ej;
            i  = (k - 1) / PER;
            ph = (k - 1) % PER;
            e_ej = 3'b000;
            if (i < ncoin[d] && ph >= 1 && ph <= P)
               e_ej = (clist[d][i] == 5) ? 3'b100 : (clist[d][i] == 2) ? 3'b010 : 3'b001;
            if (ej[d] !== e_ej) err[d]++;
            if (bsy[d] !== (k < exp_done[d])) err[d]++;
            if (dn[d] === 1'b1) begin
               if (done_at[d] == 0) done_at[d] = k;
               else err[d]++;
            end
         end
      end

      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_d%0d_done_cycle", tag, d), 32'(done_at[d]), 32'(exp_done[d]));
         chk($sformatf("%s_d%0d_wave_errs", tag, d), 32'(err[d]), 32'd0);
         chk($sformatf("%s_d%0d_remaining", tag, d), 32'(rem_o[d]), 32'(exp_rem[d]));
         chk($sformatf("%s_d%0d_short", tag, d), 32'(sh[d]), 32'(exp_rem[d] != 0));
      end
      check_tubes(tag);
   endtask

   task automatic do_restock();
      @(negedge clk);
      restock = 1'b1;
      @(negedge clk);
      restock = 1'b0;
      model_restock();
      check_tubes("restock");
   endtask

`ifdef CHANGE_INSERT_EN
   task automatic insert(input logic [7:0] v, input string tag);
      int exp_rj [3];
      int idx;
      idx = (v == 8'd5) ? 0 : (v == 8'd2) ? 1 : (v == 8'd1) ? 2 : -1;
      for (int d = 0; d < 3; d++) begin
         exp_rj[d] = 1;
         if (idx >= 0 && mt[d][idx] < 15) begin
            mt[d][idx]++;
            exp_rj[d] = 0;
         end
      end
      @(negedge clk);
      coin_pulse = 1'b1;
      coin_value = v;
      @(negedge clk);
      coin_pulse = 1'b0;
      for (int d = 0; d < 3; d++)
         chk($sformatf("%s_d%0d_reject", tag, d), 32'(rj[d]), 32'(exp_rj[d]));
      check_tubes(tag);
      @(negedge clk);
      chk({tag, "_reject_clear"}, 32'(rj[0]), 32'd0);
   endtask
`endif

   initial begin
      model_restock();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_d%0d_busy", d), 32'(bsy[d]), 32'd0);
         chk($sformatf("rst_d%0d_done", d), 32'(dn[d]), 32'd0);
         chk($sformatf("rst_d%0d_short", d), 32'(sh[d]), 32'd0);
         chk($sformatf("rst_d%0d_remaining", d), 32'(rem_o[d]), 32'd0);
         chk($sformatf("rst_d%0d_eject", d), 32'(ej[d]), 32'd0);
         chk($sformatf("rst_d%0d_reject", d), 32'(rj[d]), 32'd0);
      end
      check_tubes("rst");
      rst = 1'b1;

      dispense(8'd8, 1'b0, "amt8");
      dispense(8'd0, 1'b0, "amt0");
      dispense(8'd10, 1'b1, "amt10_restock");
      dispense(8'd9, 1'b1, "amt9_restock");
      dispense(8'd3, 1'b0, "amt3_depleted");

      // Reset during the second eject pulse of an 8 payout.
      do_restock();
      @(negedge clk);
      start = 1'b1;
      amount = 8'd8;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      chk("midrst_pre_eject2", 32'(ej[0]), 32'b010);
      rst = 1'b0;
      @(negedge clk);
      model_restock();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("midrst_d%0d_eject", d), 32'(ej[d]), 32'd0);
         chk($sformatf("midrst_d%0d_busy", d), 32'(bsy[d]), 32'd0);
      end
      check_tubes("midrst");
      rst = 1'b1;
      dispense(8'd8, 1'b0, "after_rst_amt8");

`ifdef CHANGE_INSERT_EN
      do_restock();
      dispense(8'd2, 1'b0, "pre_insert");
      insert(8'd1, "ins1_full");
      insert(8'd2, "ins2_refill");
      insert(8'd3, "ins3_bad");
      insert(8'd5, "ins5");
`endif

      for (int r = 0; r < 8; r++) begin
         logic [7:0] amt;
         bit rs;
         amt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
         rs  = ($urandom_range(0, 3) == 0);
`ifdef CHANGE_INSERT_EN
         insert(8'($urandom_range(0, 6)), $sformatf("rnd_ins%0d", r));
`endif
         dispense(amt, rs, $sformatf("rnd%0d_amt%0d", r, amt));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Drives the coin-return mechanism, the output side of the coin path that `coin_handler` feeds. On a start pulse it captures the change amount from the FSM controller and pays it out as timed eject pulses from three coin tubes (5, 2, 1), largest coin first. It tracks per-tube coin counts and reports any amount it could not pay. It sits between `fsm_controller` (`change_due`, `change_returning`) and the board's coin-ejector outputs.

## Interface
Parameters:
- `PULSE_CYCLES`, default 4: eject pulse width in clk cycles (≥1).
- `GAP_CYCLES`, default 4: idle cycles after each eject pulse (≥1).
- `TUBE5_INIT`, default 15: tube-5 count at reset/restock (0–15).
- `TUBE2_INIT`, default 15: tube-2 count at reset/restock (0–15).
- `TUBE1_INIT`, default 15: tube-1 count at reset/restock (0–15).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to dispense `amount`.
- `amount`  in  8  change value, unsigned, sampled with `start`.
- `restock`  in  1  reload all tubes to their `*_INIT` values.
- `coin_pulse`  in  1  inserted coin strobe from `coin_handler`.
- `coin_value`  in  8  value of the inserted coin.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle completion strobe.
- `short`  out  1  high when the last dispense ended with a nonzero remainder.
- `remaining`  out  8  undispensed value. Live during dispense; holds the final remainder after `done`.
- `eject5`, `eject2`, `eject1`  out  1 each  ejector drive pulses.
- `coin_reject`  out  1  one-cycle strobe when an inserted coin cannot be stored.
- `tube5`, `tube2`, `tube1`  out  4 each  current tube counts.

## Operation
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - `start`=1 latches `remaining<=amount`, clears `short`, and moves to SELECT.
  - `restock`=1 reloads the tubes.
  - If both `start` and `restock` are high, the restock applies first and the start is still accepted.
- SELECT applies the greedy rule:
  - If `remaining`≥5 and `tube5`>0, choose 5.
  - Else if `remaining`≥2 and `tube2`>0, choose 2.
  - Else if `remaining`≥1 and `tube1`>0, choose 1.
  - Else go to DONE.
  - On a choice: decrement that tube, subtract the coin value from `remaining`, then go to PULSE.
- PULSE: the chosen `ejectN` is high for exactly `PULSE_CYCLES` cycles, then go to GAP.
- GAP: all ejects low for `GAP_CYCLES` cycles, then go to SELECT.
- DONE: `done`=1 for one cycle; `short`<=(`remaining`!=0); return to IDLE.
- Ignored inputs:
  - `start` in any state other than IDLE.
  - `restock` in any state other than IDLE.
- Coin counting is greedy and non-optimal by design. Example: 3 with tube2=1, tube1=0 pays 2, leaves remainder 1, and sets `short`.
- Tube arithmetic:
  - Counts are 4-bit and saturate at 15.
  - A decrement never underflows, because SELECT checks for a nonzero count.
- Inserted coins (see Configuration):
  - A `coin_value` of 1, 2 or 5 increments the matching tube.
  - If that tube is at 15, or the value is anything else, `coin_reject` pulses and no tube changes.
  - An increment and a SELECT decrement on the same tube in the same cycle give a net change of 0.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `short`, `eject*`, `coin_reject` = 0.
  - `remaining`=0.
  - Tubes = `*_INIT`.
- Reset mid-operation takes effect at the next edge. Ejects drop immediately, and tubes reload to `*_INIT`; partial payouts are not tracked.
- `start` is sampled at edge T0:
  - `busy`=1 from T0+1.
  - SELECT occupies T0+1.
- Each coin takes 1+`PULSE_CYCLES`+`GAP_CYCLES` cycles.
  - The eject rises one cycle after its SELECT.
- For n coins, `done`=1 in cycle T0+2+n·(1+P+G), and `busy` falls in that same cycle.
- `amount`=0 gives `done` at T0+2 with no eject.
- A new `start` is accepted from the cycle after `done`.
- `coin_reject` is registered and fires 1 cycle after `coin_pulse`. Tube counts update on that same edge.

## Configuration
- Macro: `CHANGE_INSERT_EN`.
- Defined: inserted coins refill the tubes and can assert `coin_reject`, as in Operation.
- Undefined:
  - `coin_pulse` and `coin_value` are ignored.
  - `coin_reject` is tied to 0.
  - Tubes change only through reset, `restock` and dispensing.

## Test plan
- Reset, then `start` with `amount`=8 → pulses eject5, eject2, eject1, each 4 cycles wide with 4-cycle gaps. `done` at T0+29, `remaining`=0, `short`=0, tubes 14/14/14.
- `amount`=0 → `done` at T0+2, no eject, `short`=0.
- `TUBE5_INIT`=0, `amount`=10 → five eject2 pulses, `tube2`=10, `done` at T0+47.
- All `*_INIT`=1, `amount`=9 → pays 5, 2, 1; `remaining`=1, `short`=1; tubes 0/0/0.
- With `CHANGE_INSERT_EN` and `tube1`=15:
  - `coin_value`=1 → `coin_reject` pulses and `tube1` stays 15.
  - `coin_value`=2 with `tube2`=14 → `tube2` becomes 15, no reject.
  - `coin_value`=3 → reject.
- `rst`=0 during the second eject pulse of `amount`=8 → ejects low next cycle, `busy`=0, tubes 15/15/15. A new `start` for 8 then completes normally.
